draw_scheduler: RTL and testbench
=================================

# draw_scheduler

Shares the single VGA framebuffer write port between the player and enemy controllers. Each controller's `move` pulse queues a redraw. The scheduler erases the requester's previously drawn square to background, then draws the square at its current coordinates, one pixel per clock. It also performs full-screen clears on level load, and sits between the player/enemy controllers and the VGA adapter.

## Interface
- `NUM_ENEMIES`, 3: enemy requesters; total requesters `NR = NUM_ENEMIES+1`, index 0 is the player.
- `PLAYER_COLOUR`, 3'b010: player pixel colour.
- `ENEMY_COLOUR`, 3'b100: enemy pixel colour.
- `BG_COLOUR`, 3'b000: erase/clear colour.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  game in play; gates new move grants, not clears.
- `move_req`  in  NR  per-requester one-cycle move pulse.
- `req_x`  in  8*NR  packed top-left X; requester i at bits [8i+7:8i].
- `req_y`  in  7*NR  packed top-left Y.
- `req_w`  in  3*NR  packed square width, 0..7.
- `clear_req`  in  1  one-cycle pulse; clear whole screen.
- `busy`  out  1  high while not in IDLE.
- `grant`  out  NR  one-hot requester being serviced; 0 when none.
- `vga_x`  out  8  pixel X.
- `vga_y`  out  7  pixel Y.
- `vga_colour`  out  3  pixel colour.
- `vga_plot`  out  1  write strobe for the current `vga_x/vga_y/vga_colour`.

## Operation
- Reset: all outputs 0. Pending bits, clear_pending, old-position valid bits and round-robin pointer (points at requester 0) are 0.
- `move_req[i]` sets sticky `pending[i]`. `clear_req` sets `clear_pending`. A pulse while already pending is absorbed.
- States: IDLE, CLEAR, ERASE, DRAW.
- IDLE with `clear_pending`: enter CLEAR and drop `clear_pending`. Clear has priority over moves, regardless of `enable`.
- IDLE with `enable` and any pending bit: choose requester i round-robin, starting at the pointer. Then:
  - clear `pending[i]`;
  - latch `req_x/req_y/req_w` of i;
  - set `grant`;
  - move the pointer to i+1 mod NR;
  - enter ERASE.
- ERASE: if old entry i is valid and its width is nonzero, sweep its old w×w square row-major (x fastest) with `BG_COLOUR`. Otherwise go straight to DRAW.
- DRAW: sweep the latched square with `PLAYER_COLOUR` (i=0) or `ENEMY_COLOUR`. Then store the latched x/y/w as old entry i, set it valid, clear `grant`, and return to IDLE. Width 0 draws nothing but still updates the entry.
- Clipping: a pixel with x≥160 or y≥120 is not written (`vga_plot`=0), but the sweep counter still advances.
- CLEAR: sweep x 0..159, y 0..119 (19200 cycles) with `BG_COLOUR`. Then invalidate all old entries and return to IDLE. Pending move bits are kept.
- `move_req[i]` arriving while i is being serviced re-sets `pending[i]`, so i is serviced again later with fresh coordinates.
- `clear_req` during ERASE/DRAW is deferred until the current square completes.
- `enable` falling mid-service: the current square still completes.

## Timing
- All outputs are registered.
- `move_req` high in cycle t gives `pending` set at edge t+1. The grant edge is t+2 when IDLE, with `busy` and `grant` high from then.
- The first pixel strobe is in the cycle after the grant edge.
- Erase and draw each take w² cycles, back to back, with no gap between ERASE and DRAW.
- The return to IDLE edge follows the last draw pixel. The next grant can happen on the following edge.
- `reset` asserted mid-sweep immediately zeroes all outputs and state. Nothing is resumed.

## Configuration
- `DRAW_SCHED_PLAYER_PRIORITY_EN` defined: requester 0 wins whenever pending. Requesters 1..NR-1 are round-robin among themselves.
- Undefined: pure round-robin over all NR requesters.

## Test plan
- Reset, then `move_req[0]` with x=80, y=115, w=3, no prior entry: 9 plots at (80..82, 115..117) in colour 010, row-major. `busy` spans 9 cycles plus the grant cycle.
- Second `move_req[0]` at x=81: 9 plots of 000 at the old square, then 9 plots of 010 at x=81..83.
- `move_req[1]`, `move_req[2]` and `move_req[3]` in the same cycle, pointer at 1: grants in order 1, 2, 3, each exactly once.
- Enemy at x=158, w=3: columns 158..159 are plotted and column 160 has `vga_plot`=0. Sweep length is still 9 cycles.
- `clear_req` during an enemy's DRAW: the draw completes, then 19200 plots of 000, then the next erase is skipped because entries were invalidated.
- With the macro, `move_req[0]` and `move_req[2]` together with pointer at 2: requester 0 is granted first. Without the macro, requester 2 is granted first.

Source files
------------

// File: rtl/draw_scheduler.sv
// Arbitrates the single framebuffer write port between player/enemy redraws and full-screen clears.
// Define DRAW_SCHED_PLAYER_PRIORITY_EN to let the player (requester 0) pre-empt the round-robin.
module draw_scheduler #(
  parameter int         NUM_ENEMIES   = 3,
  parameter logic [2:0] PLAYER_COLOUR = 3'b010,
  parameter logic [2:0] ENEMY_COLOUR  = 3'b100,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  localparam int        NR            = NUM_ENEMIES + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NR-1:0]   move_req,
  input  logic [8*NR-1:0] req_x,
  input  logic [7*NR-1:0] req_y,
  input  logic [3*NR-1:0] req_w,
  input  logic            clear_req,
  output logic            busy,
  output logic [NR-1:0]   grant,
  output logic [7:0]      vga_x,
  output logic [6:0]      vga_y,
  output logic [2:0]      vga_colour,
  output logic            vga_plot
);

  localparam int         PW   = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [PW:0] NR_W = (PW+1)'(NR);

`ifdef DRAW_SCHED_PLAYER_PRIORITY_EN
  localparam logic PLAYER_PRIO = 1'b1;
`else
  localparam logic PLAYER_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, ERASE = 2'd2, DRAW = 2'd3} state_t;

  state_t          state_r;
  logic [NR-1:0]   pending_r;
  logic            clear_pending_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   sel_r;
  logic [7:0]      cur_x_r;
  logic [6:0]      cur_y_r;
  logic [2:0]      cur_w_r;
  logic [7:0]      old_x_r [NR];
  logic [6:0]      old_y_r [NR];
  logic [2:0]      old_w_r [NR];
  logic [NR-1:0]   old_valid_r;
  logic [7:0]      cx_r;
  logic [6:0]      cy_r;
  logic            done_r;

  logic            found_s;
  logic            hit_s;
  logic [PW-1:0]   idx_s;
  logic [PW:0]     rr_sum_s;
  logic [PW-1:0]   cand_s;
  logic [PW:0]     ptr_sum_s;
  logic [PW-1:0]   ptr_nxt_s;
  logic [7:0]      sel_x_s;
  logic [6:0]      sel_y_s;
  logic [2:0]      sel_w_s;
  logic            take_s;
  logic [NR-1:0]   onehot_s;
  logic [7:0]      base_x_s;
  logic [6:0]      base_y_s;
  logic [2:0]      sweep_w_s;
  logic [8:0]      px_x_s;
  logic [7:0]      px_y_s;
  logic            in_view_s;
  logic            last_col_s;
  logic            last_row_s;

  // Round-robin pick of the first pending requester at or after the pointer.
  always_comb begin
    found_s  = 1'b0;
    hit_s    = 1'b0;
    idx_s    = '0;
    rr_sum_s = '0;
    cand_s   = '0;
    for (int k = 0; k < NR; k++) begin
      rr_sum_s = {1'b0, ptr_r} + (PW+1)'(k);
      cand_s   = (rr_sum_s >= NR_W) ? PW'(rr_sum_s - NR_W) : rr_sum_s[PW-1:0];
      hit_s    = !found_s && pending_r[cand_s] && (!PLAYER_PRIO || (cand_s != '0));
      idx_s    = hit_s ? cand_s : idx_s;
      found_s  = found_s | hit_s;
    end
    idx_s   = (PLAYER_PRIO && pending_r[0]) ? '0 : idx_s;
    found_s = found_s | (PLAYER_PRIO && pending_r[0]);
  end

  // Coordinates of the chosen requester and the pointer value that follows it.
  always_comb begin
    sel_x_s = 8'd0;
    sel_y_s = 7'd0;
    sel_w_s = 3'd0;
    for (int k = 0; k < NR; k++) begin
      sel_x_s = (idx_s == PW'(k)) ? req_x[8*k +: 8] : sel_x_s;
      sel_y_s = (idx_s == PW'(k)) ? req_y[7*k +: 7] : sel_y_s;
      sel_w_s = (idx_s == PW'(k)) ? req_w[3*k +: 3] : sel_w_s;
    end
    ptr_sum_s = {1'b0, idx_s} + {{PW{1'b0}}, 1'b1};
    ptr_nxt_s = (ptr_sum_s >= NR_W) ? '0 : ptr_sum_s[PW-1:0];
    take_s    = (state_r == IDLE) && !clear_pending_r && enable && found_s;
    onehot_s  = {{(NR-1){1'b0}}, 1'b1} << idx_s;
  end

  // Current sweep pixel: base square plus in-square offset, widened so clipping sees overflow.
  always_comb begin
    case (state_r)
      ERASE: begin
        base_x_s  = old_x_r[sel_r];
        base_y_s  = old_y_r[sel_r];
        sweep_w_s = old_w_r[sel_r];
      end
      DRAW: begin
        base_x_s  = cur_x_r;
        base_y_s  = cur_y_r;
        sweep_w_s = cur_w_r;
      end
      default: begin
        base_x_s  = 8'd0;
        base_y_s  = 7'd0;
        sweep_w_s = 3'd0;
      end
    endcase
    px_x_s     = {1'b0, base_x_s} + {1'b0, cx_r};
    px_y_s     = {1'b0, base_y_s} + {1'b0, cy_r};
    in_view_s  = (px_x_s < 9'd160) && (px_y_s < 8'd120);
    last_col_s = (cx_r == {5'b00000, sweep_w_s - 3'd1});
    last_row_s = (cy_r == {4'b0000, sweep_w_s - 3'd1});
  end

  // Request capture, arbitration and the clear/erase/draw sweep engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      pending_r       <= '0;
      clear_pending_r <= 1'b0;
      ptr_r           <= '0;
      sel_r           <= '0;
      cur_x_r         <= 8'd0;
      cur_y_r         <= 7'd0;
      cur_w_r         <= 3'd0;
      old_valid_r     <= '0;
      cx_r            <= 8'd0;
      cy_r            <= 7'd0;
      done_r          <= 1'b0;
      for (int k = 0; k < NR; k++) begin
        old_x_r[k] <= 8'd0;
        old_y_r[k] <= 7'd0;
        old_w_r[k] <= 3'd0;
      end
      busy       <= 1'b0;
      grant      <= '0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      pending_r       <= (pending_r & ~(take_s ? onehot_s : '0)) | move_req;
      clear_pending_r <= clear_req | (clear_pending_r & (state_r != IDLE));
      case (state_r)
        IDLE: begin
          vga_plot <= 1'b0;
          cx_r     <= 8'd0;
          cy_r     <= 7'd0;
          done_r   <= 1'b0;
          if (clear_pending_r) begin
            state_r <= CLEAR;
            busy    <= 1'b1;
          end else if (take_s) begin
            sel_r   <= idx_s;
            cur_x_r <= sel_x_s;
            cur_y_r <= sel_y_s;
            cur_w_r <= sel_w_s;
            grant   <= onehot_s;
            ptr_r   <= ptr_nxt_s;
            busy    <= 1'b1;
            state_r <= (old_valid_r[idx_s] && (old_w_r[idx_s] != 3'd0)) ? ERASE : DRAW;
          end else begin
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          if (done_r) begin
            state_r     <= IDLE;
            busy        <= 1'b0;
            vga_plot    <= 1'b0;
            old_valid_r <= '0;
            done_r      <= 1'b0;
          end else begin
            vga_x      <= cx_r;
            vga_y      <= cy_r;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b1;
            if (cx_r == 8'd159) begin
              cx_r <= 8'd0;
              if (cy_r == 7'd119) done_r <= 1'b1;
              else                cy_r   <= cy_r + 7'd1;
            end else begin
              cx_r <= cx_r + 8'd1;
            end
          end
        end
        ERASE: begin
          vga_x      <= px_x_s[7:0];
          vga_y      <= px_y_s[6:0];
          vga_colour <= BG_COLOUR;
          vga_plot   <= in_view_s;
          if (last_col_s) begin
            cx_r <= 8'd0;
            if (last_row_s) begin
              cy_r    <= 7'd0;
              state_r <= DRAW;
            end else begin
              cy_r <= cy_r + 7'd1;
            end
          end else begin
            cx_r <= cx_r + 8'd1;
          end
        end
        DRAW: begin
          if (done_r || (cur_w_r == 3'd0)) begin
            state_r              <= IDLE;
            busy                 <= 1'b0;
            grant                <= '0;
            vga_plot             <= 1'b0;
            done_r               <= 1'b0;
            old_x_r[sel_r]       <= cur_x_r;
            old_y_r[sel_r]       <= cur_y_r;
            old_w_r[sel_r]       <= cur_w_r;
            old_valid_r[sel_r]   <= 1'b1;
          end else begin
            vga_x      <= px_x_s[7:0];
            vga_y      <= px_y_s[6:0];
            vga_colour <= (sel_r == '0) ? PLAYER_COLOUR : ENEMY_COLOUR;
            vga_plot   <= in_view_s;
            if (last_col_s) begin
              cx_r <= 8'd0;
              if (last_row_s) done_r <= 1'b1;
              else            cy_r   <= cy_r + 7'd1;
            end else begin
              cx_r <= cx_r + 8'd1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized and directed bench for draw_scheduler against a pixel-list reference model.
module tb_draw_scheduler;

  localparam int NR = 4;
  localparam int PLAYER_C = 2;
  localparam int ENEMY_C  = 4;
  localparam int BG_C     = 0;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NR-1:0]   move_req;
  logic [8*NR-1:0] req_x;
  logic [7*NR-1:0] req_y;
  logic [3*NR-1:0] req_w;
  logic            clear_req;
  logic            busy;
  logic [NR-1:0]   grant;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot;

  draw_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .move_req(move_req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .clear_req(clear_req),
    .busy(busy), .grant(grant), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int rx[NR], ry[NR], rw[NR];
  int m_old_x[NR], m_old_y[NR], m_old_w[NR];
  bit m_valid[NR];
  int m_ptr;
  int exp_px[$], exp_grant[$], exp_busy[$];
  int got_px[$], got_grant[$], got_busy[$];
  int g_first_busy, g_first_plot;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int enc(input int x, input int y, input int c);
    return x * 1024 + y * 8 + c;
  endfunction

  function automatic void add_square(input int x, input int y, input int w, input int c);
    for (int dy = 0; dy < w; dy++)
      for (int dx = 0; dx < w; dx++)
        if (x + dx < 160 && y + dy < 120) exp_px.push_back(enc(x + dx, y + dy, c));
  endfunction

  function automatic int pick(input bit [NR-1:0] p);
`ifdef DRAW_SCHED_PLAYER_PRIORITY_EN
    if (p[0]) return 0;
`endif
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (m_ptr + k) % NR;
`ifdef DRAW_SCHED_PLAYER_PRIORITY_EN
      if (c == 0) continue;
`endif
      if (p[c]) return c;
    end
    return 0;
  endfunction

  function automatic void model_moves(input bit [NR-1:0] mask);
    bit [NR-1:0] p;
    int i, e;
    p = mask;
    while (p != '0) begin
      i = pick(p);
      p[i] = 1'b0;
      m_ptr = (i + 1) % NR;
      e = 0;
      if (m_valid[i] && m_old_w[i] > 0) begin
        add_square(m_old_x[i], m_old_y[i], m_old_w[i], BG_C);
        e = m_old_w[i] * m_old_w[i];
      end
      add_square(rx[i], ry[i], rw[i], (i == 0) ? PLAYER_C : ENEMY_C);
      exp_grant.push_back(1 << i);
      exp_busy.push_back(e + rw[i] * rw[i] + 1);
      m_old_x[i] = rx[i]; m_old_y[i] = ry[i]; m_old_w[i] = rw[i]; m_valid[i] = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) exp_px.push_back(enc(x, y, BG_C));
    exp_busy.push_back(19201);
    for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
    m_ptr = 0;
  endfunction

  task automatic set_req(input int i, input int x, input int y, input int w);
    rx[i] = x; ry[i] = y; rw[i] = w;
    req_x[8*i +: 8] = x[7:0];
    req_y[7*i +: 7] = y[6:0];
    req_w[3*i +: 3] = w[2:0];
  endtask

  task automatic pulse(input bit [NR-1:0] mask);
    @(negedge clk);
    move_req = mask;
    @(negedge clk);
    move_req = '0;
    check("pre_grant_busy", int'(busy), 0);
  endtask

  task automatic collect(input int budget, input int clr_at);
    int prev, run, streak;
    bit done;
    got_px.delete(); got_grant.delete(); got_busy.delete();
    prev = 0; run = 0; streak = 0; done = 1'b0;
    g_first_busy = -1; g_first_plot = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      clear_req = (c == clr_at);
      if (vga_plot) begin
        got_px.push_back(enc(int'(vga_x), int'(vga_y), int'(vga_colour)));
        if (g_first_plot < 0) g_first_plot = c;
      end
      if (grant != '0 && prev == 0) got_grant.push_back(int'(grant));
      prev = int'(grant);
      if (busy) begin
        if (g_first_busy < 0) g_first_busy = c;
        run++;
        streak = 0;
      end else begin
        if (run > 0) got_busy.push_back(run);
        run = 0;
        streak++;
        if (streak >= 3) done = 1'b1;
      end
    end
    clear_req = 1'b0;
    check("collect_done", int'(done), 1);
  endtask

  task automatic compare(input string tag);
    int nbad, n;
    nbad = 0;
    check({tag, "_px_len"}, got_px.size(), exp_px.size());
    n = (got_px.size() < exp_px.size()) ? got_px.size() : exp_px.size();
    for (int i = 0; i < n; i++) if (got_px[i] != exp_px[i]) nbad++;
    check({tag, "_px_bad"}, nbad, 0);
    check({tag, "_n_grant"}, got_grant.size(), exp_grant.size());
    n = (got_grant.size() < exp_grant.size()) ? got_grant.size() : exp_grant.size();
    for (int i = 0; i < n; i++) check({tag, "_grant"}, got_grant[i], exp_grant[i]);
    check({tag, "_n_busy"}, got_busy.size(), exp_busy.size());
    n = (got_busy.size() < exp_busy.size()) ? got_busy.size() : exp_busy.size();
    for (int i = 0; i < n; i++) check({tag, "_busy_len"}, got_busy[i], exp_busy[i]);
  endtask

  task automatic burst(input bit [NR-1:0] mask, input string tag);
    exp_px.delete(); exp_grant.delete(); exp_busy.delete();
    model_moves(mask);
    pulse(mask);
    collect(3000, -1);
    compare(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_grant"}, int'(grant), 0);
    check({tag, "_plot"}, int'(vga_plot), 0);
    check({tag, "_x"}, int'(vga_x), 0);
    check({tag, "_y"}, int'(vga_y), 0);
    check({tag, "_colour"}, int'(vga_colour), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, clr_at;
    reset = 1'b1; enable = 1'b0; move_req = '0; clear_req = 1'b0;
    req_x = '0; req_y = '0; req_w = '0;
    for (int i = 0; i < NR; i++) set_req(i, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    enable = 1'b1;

    // first player draw: no erase, latency of grant and first plot
    set_req(0, 80, 115, 3);
    burst(4'b0001, "player_first");
    check("lat_busy", g_first_busy, 0);
    check("lat_plot", g_first_plot, 1);

    set_req(0, 81, 115, 3);
    burst(4'b0001, "player_move");

    set_req(1, 10, 10, 2);
    set_req(2, 30, 40, 4);
    set_req(3, 100, 5, 5);
    burst(4'b1110, "rr_three");

    set_req(1, 158, 50, 3);
    burst(4'b0010, "clip_x");
    set_req(2, 10, 118, 5);
    burst(4'b0100, "clip_y");

    set_req(1, 60, 60, 2);
    burst(4'b0010, "ptr_to_2");
    set_req(0, 5, 5, 2);
    set_req(2, 70, 70, 3);
    burst(4'b0101, "prio");

    // enable low holds the request pending
    enable = 1'b0;
    set_req(3, 120, 90, 4);
    pulse(4'b1000);
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("hold_busy", nb, 0);
    enable = 1'b1;
    exp_px.delete(); exp_grant.delete(); exp_busy.delete();
    model_moves(4'b1000);
    collect(3000, -1);
    compare("enable_release");

    // clear requested in the middle of an enemy draw
    set_req(1, 40, 20, 4);
    clr_at = 1 + (m_valid[1] ? m_old_w[1] * m_old_w[1] : 0) + 3;
    exp_px.delete(); exp_grant.delete(); exp_busy.delete();
    model_moves(4'b0010);
    model_clear();
    pulse(4'b0010);
    collect(25000, clr_at);
    compare("clear_mid_draw");
    set_req(1, 44, 22, 3);
    burst(4'b0010, "after_clear");

    // randomized bursts
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NR; i++)
        set_req(i, ($urandom_range(0, 7) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 175),
                $urandom_range(0, 127), $urandom_range(0, 7));
      burst(4'($urandom_range(1, 15)), "rnd");
    end

    // reset in the middle of a sweep
    set_req(0, 20, 20, 7);
    pulse(4'b0001);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    burst(4'b0001, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
